// File: rtl/alu4_pkg.sv
// Shared types and constants for the 4-bit ALU arbiter slice.
// Opcodes, FSM state encoding and the latched command bundle.
package alu4_pkg;

  localparam int ALU4_W    = 4;
  localparam int ALU4_OP_W = 3;

  localparam logic [ALU4_OP_W-1:0] ALU4_OP_ADD  = 3'b000;
  localparam logic [ALU4_OP_W-1:0] ALU4_OP_SUB  = 3'b001;
  localparam logic [ALU4_OP_W-1:0] ALU4_OP_AND  = 3'b010;
  localparam logic [ALU4_OP_W-1:0] ALU4_OP_OR   = 3'b011;
  localparam logic [ALU4_OP_W-1:0] ALU4_OP_XOR  = 3'b100;
  localparam logic [ALU4_OP_W-1:0] ALU4_OP_NOT  = 3'b101;
  localparam logic [ALU4_OP_W-1:0] ALU4_OP_PASS = 3'b110;
  localparam logic [ALU4_OP_W-1:0] ALU4_OP_NOP  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } alu4_arb_state_t;

  typedef struct packed {
    logic                 id;
    logic [ALU4_OP_W-1:0] op;
    logic [ALU4_W-1:0]    a;
    logic [ALU4_W-1:0]    b;
  } alu4_cmd_t;

endpackage

// File: rtl/alu4_core.sv
// Combinational 4-bit ALU: opcode/A/B to {carry, result}.
// Carry is bit 4 of a 5-bit evaluation of each operation.
module alu4_core
  import alu4_pkg::*;
(
  input  logic [ALU4_OP_W-1:0] op,
  input  logic [ALU4_W-1:0]    a,
  input  logic [ALU4_W-1:0]    b,
  output logic [ALU4_W-1:0]    result,
  output logic                 carry
);

  logic [ALU4_W:0] ax;
  logic [ALU4_W:0] bx;
  logic [ALU4_W:0] y;

  assign ax = {1'b0, a};
  assign bx = {1'b0, b};

  // SUB wraps modulo 32, so bit 4 doubles as the borrow flag
  always_comb begin
    y = '0;
    unique case (op)
      ALU4_OP_ADD:  y = ax + bx;
      ALU4_OP_SUB:  y = ax - bx;
      ALU4_OP_AND:  y = ax & bx;
      ALU4_OP_OR:   y = ax | bx;
      ALU4_OP_XOR:  y = ax ^ bx;
      ALU4_OP_NOT:  y = ~ax;
      ALU4_OP_PASS: y = bx;
      ALU4_OP_NOP:  y = '0;
    endcase
  end

  assign result = y[ALU4_W-1:0];
  assign carry  = y[ALU4_W];

endmodule

// File: rtl/alu4_arb_ctrl.sv
// Round-robin two-requester front end for alu4_core.
// Define ALU4_ARB_ZERO_FLAG_EN to add the rsp_zero output.
module alu4_arb_ctrl
  import alu4_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [ALU4_OP_W-1:0] req0_op,
  input  logic [ALU4_W-1:0]    req0_a,
  input  logic [ALU4_W-1:0]    req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [ALU4_OP_W-1:0] req1_op,
  input  logic [ALU4_W-1:0]    req1_a,
  input  logic [ALU4_W-1:0]    req1_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [ALU4_W-1:0]    rsp_result,
  output logic                 rsp_carry,
`ifdef ALU4_ARB_ZERO_FLAG_EN
  output logic                 rsp_zero,
`endif
  output logic                 busy
);

  alu4_arb_state_t state;
  alu4_cmd_t       cmd;
  alu4_cmd_t       pick;
  logic            last_grant;
  logic            any_valid;
  logic            sel;
  logic            can_issue;
  logic            take;
  logic [ALU4_W-1:0] core_res;
  logic              core_carry;

  assign any_valid = req0_valid | req1_valid;

  // On a tie the requester that did not win last time goes next
  assign sel = (req0_valid & req1_valid) ? ~last_grant
                                         : req1_valid;

  assign can_issue  = (state == ST_IDLE) & ~rst & any_valid;
  assign req0_ready = can_issue & ~sel;
  assign req1_ready = can_issue & sel;
  assign take       = (req0_valid & req0_ready)
                    | (req1_valid & req1_ready);

  always_comb begin
    pick = '0;
    if (sel) begin
      pick.id = 1'b1;
      pick.op = req1_op;
      pick.a  = req1_a;
      pick.b  = req1_b;
    end else begin
      pick.id = 1'b0;
      pick.op = req0_op;
      pick.a  = req0_a;
      pick.b  = req0_b;
    end
  end

  alu4_core u_core (
    .op     (cmd.op),
    .a      (cmd.a),
    .b      (cmd.b),
    .result (core_res),
    .carry  (core_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      cmd        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
`ifdef ALU4_ARB_ZERO_FLAG_EN
      rsp_zero   <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (take) begin
            cmd        <= pick;
            last_grant <= pick.id;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_id     <= cmd.id;
          rsp_result <= core_res;
          rsp_carry  <= core_carry;
`ifdef ALU4_ARB_ZERO_FLAG_EN
          rsp_zero   <= (core_res == '0);
`endif
          rsp_valid  <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
